btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//   Multi-channel push-button conditioner for front-panel inputs. Each raw async
//   button is synchronised, debounced against a programmable sample-tick rate,
//   and reported as a clean level plus one-cycle rise/fall strobes.
//   Sits between board pins and the control FSMs; replaces ad-hoc per-button
//   edge detectors and fixed clock dividers.
// PARAMETERS
//   CHANNELS      4   number of independent button channels
//   CNT_W         16  width of sample-period input and prescaler counter
//   STABLE_TICKS  4   consecutive differing sample ticks required to accept a change (>=1)
//   SYNC_STAGES   2   synchroniser flops per channel (>=2)
// PORTS
//   clk     in   1         system clock, all logic on posedge
//   rst_n   in   1         asynchronous active-low reset
//   period  in   CNT_W     sample-tick period in clk cycles (0 treated as 1)
//   btn     in   CHANNELS  raw asynchronous button inputs
//   tick    out  1         sample strobe, high one cycle per period
//   level   out  CHANNELS  debounced button state
//   rise    out  CHANNELS  one-cycle pulse on level 0->1
//   fall    out  CHANNELS  one-cycle pulse on level 1->0
// BEHAVIOUR
//   Reset (rst_n low, async): sync flops, level, rise, fall, tick, prescaler
//     count, stability counters all 0. Clears immediately, no clock needed.
//   Prescaler: cnt==0 -> tick<=1, cnt<=period-1 (period 0 reloads 0);
//     else tick<=0, cnt<=cnt-1. First tick is registered on the first posedge
//     after reset release. period changes take effect at next reload only.
//     period 0 or 1 -> tick high every cycle.
//   Sync: btn[i] through SYNC_STAGES flops; s[i] = last stage.
//   Debounce, per channel, only on cycles where tick==1:
//     s==level            -> stab<=0
//     s!=level, stab==STABLE_TICKS-1 -> level<=s, stab<=0
//     s!=level, otherwise -> stab<=stab+1
//     non-tick cycles hold stab and level. stab width = clog2(STABLE_TICKS+1).
//   Any tick sampling s==level (bounce) restarts the count from 0.
//   STABLE_TICKS=1: level takes s at every tick.
//   Strobes: rise/fall registered on same edge as level update; rise[i] high
//     exactly the first cycle level[i] reads 1, fall[i] the first cycle it
//     reads 0; low in all other cycles. rise and fall never both high on a channel.
//   Latency: btn edge -> s after SYNC_STAGES clks; level changes on the
//     STABLE_TICKS-th qualifying tick after that.
//   Channels fully independent; simultaneous changes give simultaneous strobes.
//   Reset mid-operation: all state cleared; button held high through reset
//     release is re-debounced from level=0 and produces a rise pulse.
// TESTING
//   1 period=4, STABLE_TICKS=4, btn=4'b0001 held through reset release ->
//     tick every 4th clk; exactly one rise[0] within 2+16+4 clks; level=4'b0001.
//   2 btn[1] toggles every 3 clks for 60 clks, period=4 -> level[1] stays 0,
//     rise/fall never asserted; after btn[1] held 1 -> single rise[1].
//   3 clean press held 40 clks then release, period=2 -> one rise, then one
//     fall, each exactly 1 cycle wide; level matches held value.
//   4 period=0 then period=1, STABLE_TICKS=4 -> tick constant 1; level
//     follows btn change exactly 2+4 clks later.
//   5 btn 4'b0000->4'b1111 in one cycle -> rise=4'b1111 in a single cycle.
//   6 rst_n low mid-count with clk stopped -> level/rise/fall/tick 0 at once;
//     after release behaviour as in scenario 1.

Source files
------------

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: per-channel synchroniser, tick-paced
// debouncer and one-cycle rise/fall strobes, sharing one programmable prescaler.
module btn_conditioner #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 16,
  parameter int STABLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT_W-1:0]    period,
  input  logic [CHANNELS-1:0] btn,
  output logic                tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int STAB_W = $clog2(STABLE_TICKS + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

  logic [CNT_W-1:0]    r_cnt;
  logic                r_tick;
  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [STAB_W-1:0]   r_stab [CHANNELS];
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CHANNELS-1:0] w_s;

  // Period is only sampled on reload, so a mid-count change never shortens a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == '0) begin
      r_tick <= 1'b1;
      r_cnt  <= (period == '0) ? '0 : period - CNT_W'(1);
    end else begin
      r_tick <= 1'b0;
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= btn;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Any tick that sees the input agree with the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) r_stab[i] <= '0;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      if (r_tick) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (w_s[i] == r_level[i]) begin
            r_stab[i] <= '0;
          end else if (r_stab[i] == STAB_LAST) begin
            r_level[i] <= w_s[i];
            r_rise[i]  <= w_s[i];
            r_fall[i]  <= ~w_s[i];
            r_stab[i]  <= '0;
          end else begin
            r_stab[i] <= r_stab[i] + STAB_W'(1);
          end
        end
      end
    end
  end

  assign tick  = r_tick;
  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: a per-cycle vector table at tick-every-cycle
// plus hand-written sequences for power-up, bounce, strobes and async reset.
module tb_btn_conditioner;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst_n = 1'b0;
  logic [15:0] period = 16'd4;
  logic [3:0]  btn = 4'b0001;
  logic        tick;
  logic [3:0]  level, rise, fall;

  int n_tests = 0;
  int n_fail = 0;
  int n_overlap = 0;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl [26];

  btn_conditioner #(
    .CHANNELS(4), .CNT_W(16), .STABLE_TICKS(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .period(period), .btn(btn),
    .tick(tick), .level(level), .rise(rise), .fall(fall)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (|(rise & fall)) n_overlap++;
  endtask

  task automatic set_vec(input int i, input logic [3:0] b, input logic [3:0] l,
                         input logic [3:0] r, input logic [3:0] f);
    tbl[i].btn = b; tbl[i].level = l; tbl[i].rise = r; tbl[i].fall = f;
  endtask

  // Release has just happened with btn=0001, period=4: expect ticks on cycles
  // 1,5,9,... and a single rise[0] on cycle 18.
  task automatic power_up_check(input string tag);
    int ticks = 0, tick_bad = 0, rises = 0, other = 0, rise_cyc = 0;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (tick) ticks++;
      if (tick != (c % 4 == 1)) tick_bad++;
      if (rise[0]) begin rises++; rise_cyc = c; end
      if (|rise[3:1] || |fall) other++;
    end
    check({tag, "_tick_count"}, ticks, 6);
    check({tag, "_tick_phase"}, tick_bad, 0);
    check({tag, "_rise0_count"}, rises, 1);
    check({tag, "_rise0_cycle"}, rise_cyc, 18);
    check({tag, "_other_strobes"}, other, 0);
    check({tag, "_level"}, level, 4'b0001);
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_c;

    set_vec( 0, 4'h1, 4'h0, 4'h0, 4'h0);
    set_vec( 1, 4'h1, 4'h0, 4'h0, 4'h0);
    set_vec( 2, 4'h1, 4'h0, 4'h0, 4'h0);
    set_vec( 3, 4'h1, 4'h0, 4'h0, 4'h0);
    set_vec( 4, 4'h1, 4'h0, 4'h0, 4'h0);
    set_vec( 5, 4'h1, 4'h1, 4'h1, 4'h0);
    set_vec( 6, 4'h1, 4'h1, 4'h0, 4'h0);
    set_vec( 7, 4'h0, 4'h1, 4'h0, 4'h0);
    set_vec( 8, 4'h1, 4'h1, 4'h0, 4'h0);
    set_vec( 9, 4'h1, 4'h1, 4'h0, 4'h0);
    set_vec(10, 4'h1, 4'h1, 4'h0, 4'h0);
    set_vec(11, 4'h1, 4'h1, 4'h0, 4'h0);
    set_vec(12, 4'h0, 4'h1, 4'h0, 4'h0);
    set_vec(13, 4'h0, 4'h1, 4'h0, 4'h0);
    set_vec(14, 4'h0, 4'h1, 4'h0, 4'h0);
    set_vec(15, 4'h0, 4'h1, 4'h0, 4'h0);
    set_vec(16, 4'h0, 4'h1, 4'h0, 4'h0);
    set_vec(17, 4'h0, 4'h0, 4'h0, 4'h1);
    set_vec(18, 4'h0, 4'h0, 4'h0, 4'h0);
    set_vec(19, 4'h1, 4'h0, 4'h0, 4'h0);
    set_vec(20, 4'h1, 4'h0, 4'h0, 4'h0);
    set_vec(21, 4'h1, 4'h0, 4'h0, 4'h0);
    set_vec(22, 4'h0, 4'h0, 4'h0, 4'h0);
    set_vec(23, 4'h0, 4'h0, 4'h0, 4'h0);
    set_vec(24, 4'h0, 4'h0, 4'h0, 4'h0);
    set_vec(25, 4'h0, 4'h0, 4'h0, 4'h0);

    // Power-up with button held through reset release
    repeat (3) step();
    check("reset_level", level, 4'h0);
    check("reset_rise", rise, 4'h0);
    check("reset_fall", fall, 4'h0);
    check("reset_tick", tick, 1'b0);
    rst_n = 1'b1;
    power_up_check("pwrup");

    // btn[1] bouncing every 3 clocks never qualifies
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 3 == 0) btn[1] = ~btn[1];
      step();
      if (rise[1] || fall[1]) cnt_a++;
      if (level[1]) cnt_b++;
    end
    check("bounce_strobes", cnt_a, 0);
    check("bounce_level_high_cycles", cnt_b, 0);
    btn[1] = 1'b1;
    cnt_a = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (rise[1]) cnt_a++;
    end
    check("bounce_then_hold_rise", cnt_a, 1);
    check("bounce_then_hold_level", level, 4'b0011);

    // Clean press and release at period 2
    period = 16'd2;
    btn[2] = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (rise[2]) cnt_a++;
      if (fall[2]) cnt_b++;
    end
    check("press_rise_cycles", cnt_a, 1);
    check("press_fall_cycles", cnt_b, 0);
    check("press_level", level, 4'b0111);
    btn[2] = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (rise[2]) cnt_a++;
      if (fall[2]) cnt_b++;
    end
    check("release_rise_cycles", cnt_a, 0);
    check("release_fall_cycles", cnt_b, 1);
    check("release_level", level, 4'b0011);

    // Period 0 then 1: tick every cycle; vector table at one tick per clock
    rst_n = 1'b0;
    period = 16'd0;
    btn = 4'h0;
    #2;
    check("midrun_reset_level", level, 4'h0);
    step();
    rst_n = 1'b1;
    cnt_a = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (tick) cnt_a++;
    end
    check("period0_tick_cycles", cnt_a, 8);
    period = 16'd1;
    cnt_a = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (tick) cnt_a++;
    end
    check("period1_tick_cycles", cnt_a, 4);

    for (int i = 0; i < 26; i++) begin
      btn = tbl[i].btn;
      step();
      check($sformatf("tbl[%0d].level", i), level, tbl[i].level);
      check($sformatf("tbl[%0d].rise", i), rise, tbl[i].rise);
      check($sformatf("tbl[%0d].fall", i), fall, tbl[i].fall);
      check($sformatf("tbl[%0d].tick", i), tick, 1'b1);
    end

    // All channels pressed in the same cycle
    btn = 4'b1111;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (rise == 4'b1111) begin cnt_a++; cnt_c = c; end
      else if (rise != 4'h0) cnt_b++;
    end
    check("simul_rise_all", cnt_a, 1);
    check("simul_rise_partial", cnt_b, 0);
    check("simul_rise_cycle", cnt_c, 6);
    check("simul_level", level, 4'b1111);

    // Async reset with the clock stopped, then power-up again
    @(negedge clk);
    clk_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_level", level, 4'h0);
    check("async_rst_rise", rise, 4'h0);
    check("async_rst_fall", fall, 4'h0);
    check("async_rst_tick", tick, 1'b0);
    btn = 4'b0001;
    period = 16'd4;
    #10;
    rst_n = 1'b1;
    #2;
    clk_en = 1'b1;
    power_up_check("rst_pwrup");

    check("rise_fall_overlap", n_overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
